// File: rtl/piccolo_byte_loader.sv
// rtl/piccolo_byte_loader.sv - byte-serial key/plaintext loader and ciphertext unloader for the Piccolo core
// Frame: 10 or 16 key bytes then 8 plaintext bytes in; 8 ciphertext bytes out, MSB first.
module piccolo_byte_loader #(
  parameter int CORE_LAT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         version,
  input  logic [7:0]   din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [7:0]   dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         core_rst,
  output logic         core_version,
  output logic [0:63]  core_plaintext,
  output logic [0:127] core_key,
  input  logic [0:63]  core_ciphertext
);

  localparam int WW = $clog2(CORE_LAT + 1);

  typedef enum logic [2:0] {
    S_LOAD_KEY,
    S_LOAD_PT,
    S_START,
    S_WAIT,
    S_SEND
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic           ver_q, ver_d;
  logic [0:63]    pt_q, pt_d;
  logic [0:127]   key_q, key_d;
  logic [0:63]    sr_q, sr_d;
  logic           din_ready_q, din_ready_d;
  logic           dout_valid_q, dout_valid_d;
  logic           in_hs, out_hs;
  logic [3:0]     key_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_LOAD_KEY;
      cnt_q        <= '0;
      wait_q       <= '0;
      ver_q        <= 1'b0;
      pt_q         <= '0;
      key_q        <= '0;
      sr_q         <= '0;
      din_ready_q  <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      ver_q        <= ver_d;
      pt_q         <= pt_d;
      key_q        <= key_d;
      sr_q         <= sr_d;
      din_ready_q  <= din_ready_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    ver_d    = ver_q;
    pt_d     = pt_q;
    key_d    = key_q;
    sr_d     = sr_q;
    in_hs    = din_ready_q & din_valid;
    out_hs   = dout_valid_q & dout_ready;
    // The key length follows the live version only on the first byte of a frame.
    key_last = ((cnt_q == 4'd0) ? version : ver_q) ? 4'd15 : 4'd9;

    case (state_q)
      S_LOAD_KEY: begin
        if (in_hs) begin
          if (cnt_q == 4'd0) begin
            ver_d = version;
            key_d = '0;
          end
          key_d[{cnt_q, 3'b000} +: 8] = din;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == key_last) state_d = S_LOAD_PT;
        end
      end
      S_LOAD_PT: begin
        if (in_hs) begin
          pt_d  = {pt_q[8:63], din};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        wait_d  = WW'(CORE_LAT - 1);
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          sr_d    = core_ciphertext;
          state_d = S_SEND;
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      S_SEND: begin
        if (out_hs) begin
          sr_d  = {sr_q[8:63], 8'h00};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) state_d = S_LOAD_KEY;
        end
      end
      default: state_d = S_LOAD_KEY;
    endcase

    if (state_d != state_q) cnt_d = '0;

    din_ready_d  = (state_d == S_LOAD_KEY) || (state_d == S_LOAD_PT);
    dout_valid_d = (state_d == S_SEND);
  end

  assign din_ready      = din_ready_q;
  assign dout_valid     = dout_valid_q;
  assign dout           = sr_q[0:7];
  assign core_rst       = (state_q != S_WAIT);
  assign core_version   = ver_q;
  assign core_plaintext = pt_q;
  assign core_key       = key_q;

endmodule

// File: tb/tb_piccolo_byte_loader.sv
// tb/tb_piccolo_byte_loader.sv - directed bench for piccolo_byte_loader with a stub core
// Stub core answers the Piccolo-80 known-answer vector, otherwise ct = pt ^ key[0:63].
module tb_piccolo_byte_loader;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         version = 1'b0;
  logic [7:0]   din = 8'h00;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [7:0]   dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         core_rst;
  logic         core_version;
  logic [0:63]  core_plaintext;
  logic [0:127] core_key;
  logic [0:63]  core_ciphertext = 64'h0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_hs_cyc = 0;

  piccolo_byte_loader #(.CORE_LAT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .version        (version),
    .din            (din),
    .din_valid      (din_valid),
    .din_ready      (din_ready),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .dout_ready     (dout_ready),
    .core_rst       (core_rst),
    .core_version   (core_version),
    .core_plaintext (core_plaintext),
    .core_key       (core_key),
    .core_ciphertext(core_ciphertext)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (core_rst) begin
      if (!core_version && core_key[0:79] == 80'h00112233445566778899 &&
          core_plaintext == 64'h0123456789abcdef)
        core_ciphertext <= 64'h8d2bff9935f84056;
      else
        core_ciphertext <= core_plaintext ^ core_key[0:63];
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_cycle();
    din_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    int  n = 0;
    logic rdy = 1'b0;
    din = b;
    din_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = din_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 100);
    #1;
    din_valid = 1'b0;
    last_hs_cyc = cyc;
    if (!rdy) chk("din_hs_timeout", rdy, 1);
  endtask

  task automatic load_frame(input bit ver, input logic [127:0] key, input logic [63:0] pt,
                            input bit gaps, input bit flip);
    int nkey = ver ? 16 : 10;
    for (int i = 0; i < nkey; i++) begin
      if (gaps) repeat ($urandom_range(0, 1)) idle_cycle();
      if (i == 0) version = ver;
      if (flip && i == 1) version = ~ver;
      put_byte(key[127 - 8*i -: 8]);
    end
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 1)) idle_cycle();
      put_byte(pt[63 - 8*i -: 8]);
    end
  endtask

  task automatic get_frame(input string tag, input bit bp, output logic [63:0] ct, output int lat);
    int   n = 0;
    int   g = 0;
    int   first = -1;
    bit   tog = 1'b1;
    bit   stall = 1'b0;
    logic [7:0] held = 8'h00;
    ct = 64'h0;
    while (n < 8 && g < 300) begin
      @(negedge clk);
      g++;
      dout_ready = bp ? tog : 1'b1;
      tog = ~tog;
      if (dout_valid) begin
        if (first < 0) first = cyc;
        if (stall) chk({tag, "_hold"}, dout, held);
        if (dout_ready) begin
          ct = {ct[55:0], dout};
          n++;
          stall = 1'b0;
        end else begin
          held = dout;
          stall = 1'b1;
        end
      end
    end
    chk({tag, "_count"}, n, 8);
    lat = first - last_hs_cyc;
    @(negedge clk);
    chk({tag, "_valid_after"}, dout_valid, 0);
    chk({tag, "_ready_after"}, din_ready, 1);
    dout_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [63:0] ct;
    int          lat;

    // Reset values
    #3;
    chk("rst_din_ready", din_ready, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_version", core_version, 0);
    chk("rst_core_pt", core_plaintext, 0);
    chk("rst_core_key", core_key, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_din_ready", din_ready, 1);
    chk("post_rst_dout_valid", dout_valid, 0);

    // Piccolo-80 known answer, back-to-back
    load_frame(1'b0, {80'h00112233445566778899, 48'h0}, 64'h0123456789abcdef, 1'b0, 1'b0);
    @(negedge clk);
    chk("kat_start_core_rst", core_rst, 1);
    chk("kat_start_din_ready", din_ready, 0);
    chk("kat_key", core_key, {80'h00112233445566778899, 48'h0});
    chk("kat_key_hi_zero", core_key[80:127], 0);
    chk("kat_pt", core_plaintext, 64'h0123456789abcdef);
    chk("kat_version", core_version, 0);
    @(negedge clk);
    chk("kat_wait_core_rst", core_rst, 0);
    get_frame("kat", 1'b0, ct, lat);
    chk("kat_ct", ct, 64'h8d2bff9935f84056);
    chk("kat_latency", lat, 5);

    // Piccolo-128 with dout_ready toggling
    load_frame(1'b1, 128'h00112233445566778899aabbccddeeff, 64'h0123456789abcdef, 1'b0, 1'b0);
    chk("p128_version", core_version, 1);
    chk("p128_key", core_key, 128'h00112233445566778899aabbccddeeff);
    get_frame("p128", 1'b1, ct, lat);
    chk("p128_ct", ct, 64'h01326754cdfeab98);

    // Random input gaps, version flipped after the first key byte
    load_frame(1'b0, {80'ha55a0ff0123456789abc, 48'h0}, 64'hfedcba9876543210, 1'b1, 1'b1);
    chk("gap_version", core_version, 0);
    chk("gap_key", core_key, {80'ha55a0ff0123456789abc, 48'h0});
    chk("gap_pt", core_plaintext, 64'hfedcba9876543210);
    get_frame("gap", 1'b0, ct, lat);
    chk("gap_ct", ct, 64'h5b86b56864606468);

    // Reset after 5 key bytes, then a fresh frame
    version = 1'b1;
    for (int i = 0; i < 5; i++) put_byte(8'h10 + 8'(i));
    reset = 1'b1;
    #2;
    chk("mid_rst_din_ready", din_ready, 0);
    chk("mid_rst_key", core_key, 0);
    chk("mid_rst_version", core_version, 0);
    chk("mid_rst_core_rst", core_rst, 1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rst_no_dout", dout_valid, 0);
    end
    @(posedge clk);
    #1;
    load_frame(1'b0, {80'h112233445566778899aa, 48'h0}, 64'h0, 1'b0, 1'b0);
    chk("mid_rst_new_key", core_key, {80'h112233445566778899aa, 48'h0});
    get_frame("mid_rst", 1'b0, ct, lat);
    chk("mid_rst_ct", ct, 64'h1122334455667788);

    // Back-to-back frames: version 0 then version 1
    load_frame(1'b0, {80'hffeeddccbbaa99887766, 48'h0}, 64'h0011223344556677, 1'b0, 1'b0);
    chk("b2b0_key", core_key, {80'hffeeddccbbaa99887766, 48'h0});
    get_frame("b2b0", 1'b0, ct, lat);
    chk("b2b0_ct", ct, 64'hffffffffffffffff);
    chk("b2b0_latency", lat, 5);
    load_frame(1'b1, 128'h00112233445566778899aabbccddeeff, 64'hffffffffffffffff, 1'b0, 1'b0);
    chk("b2b1_key", core_key, 128'h00112233445566778899aabbccddeeff);
    chk("b2b1_version", core_version, 1);
    get_frame("b2b1", 1'b0, ct, lat);
    chk("b2b1_ct", ct, 64'hffeeddccbbaa9988);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piccolo_byte_loader.md
# piccolo_byte_loader

Byte-serial front/back end for the unrolled Piccolo encryption core. It accepts key and plaintext bytes over a valid/ready stream, assembles the 64-bit plaintext and the 80/128-bit key, and drives the core's reset/load. After a fixed latency it captures the 64-bit ciphertext and returns it as 8 bytes over a second valid/ready stream. It sits directly between the system byte bus and the Piccolo core: upstream of the core's plaintext/key inputs and downstream of its ciphertext output.

## Interface
Parameters:
- CORE_LAT, 4, cycles spent in WAIT after the core load cycle; must be ≥ 4.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- version  in  1  key size select: 0 = Piccolo-80 (10 key bytes), 1 = Piccolo-128 (16 key bytes). Sampled on the first key byte of a frame.
- din  in  8  input byte.
- din_valid  in  1  din holds a byte.
- din_ready  out  1  loader accepts din this cycle.
- dout  out  8  ciphertext byte.
- dout_valid  out  1  dout holds a byte.
- dout_ready  in  1  sink accepts dout this cycle.
- core_rst  out  1  drives the core reset/load input.
- core_version  out  1  latched version to the core.
- core_plaintext  out  [0:63]  assembled plaintext.
- core_key  out  [0:127]  assembled key; Piccolo-80 uses [0:79], with [80:127] = 0.
- core_ciphertext  in  [0:63]  core output.

## Operation
- Frame format: key bytes, MSB first (byte 0 → key[0:7]), followed by 8 plaintext bytes, MSB first (byte 0 → plaintext[0:7]).
- FSM states and transitions:
  - LOAD_KEY: din_ready = 1. Each handshake (din_valid & din_ready) shifts one byte in. The first byte latches version into core_version. The state exits after 10 bytes (version 0) or 16 bytes (version 1).
  - LOAD_PT: din_ready = 1. The state exits after 8 bytes.
  - START: one cycle, core_rst = 1, din_ready = 0. The core samples the plaintext and key at this edge.
  - WAIT: core_rst = 0 for CORE_LAT cycles, tracked by a down-counter. core_ciphertext is sampled into the output shift register at the final WAIT edge, then the FSM moves to SEND.
  - SEND: dout_valid = 1, dout = shift register[0:7]. Each handshake shifts by 8. After the 8th handshake the FSM returns to LOAD_KEY.
- core_rst = 1 in every state except WAIT, so the core stays parked while loading.
- At the START of each LOAD_KEY frame, key bits not written by the frame are zeroed.
- Byte counter is 4 bits and is cleared on every state change. There is no wrap inside a state.
- version changes mid-frame are ignored until the next frame.
- din is ignored outside the LOAD states: din_ready = 0, so no data is lost.
- dout and the shift register hold while dout_valid & !dout_ready (backpressure), with no timeout.
- Reset mid-operation aborts the frame. A partial key, plaintext or ciphertext is discarded. No output byte is emitted after reset deasserts until a new full frame has been loaded.

## Timing
- Reset values:
  - state = LOAD_KEY.
  - din_ready = 1 after reset deasserts; 0 while reset is asserted.
  - dout = 0, dout_valid = 0.
  - core_rst = 1, core_version = 0.
  - core_plaintext = 0, core_key = 0, all counters = 0.
- Input acceptance is one byte per cycle at full rate.
- Latency from the last plaintext handshake edge to the first dout_valid cycle is 1 (START) + CORE_LAT cycles.
- Output drains at one byte per cycle when dout_ready is held high.
- Minimum frame period, Piccolo-80: 10 + 8 + 1 + CORE_LAT + 8 = 31 cycles at the default CORE_LAT.
- din_ready and dout_valid are registered state decodes and never both 1 in the same cycle.

## Test plan
- Reset check: reset pulse then idle → all outputs at their reset values, din_ready = 1 once reset is low.
- Piccolo-80 known answer, real core:
  - Stimulus: version = 0, key 00112233445566778899, plaintext 0123456789abcdef, streamed back-to-back.
  - Required response: dout bytes 8d,2b,ff,99,35,f8,40,56, with first dout_valid 5 cycles after the last din handshake.
  - core_key[80:127] = 0.
- Piccolo-128 with backpressure:
  - Stimulus: version = 1, key 00112233445566778899aabbccddeeff, plaintext 0123456789abcdef; dout_ready toggles 1/0 every cycle.
  - Required response: bytes match the golden model, each byte held stable while dout_ready = 0, exactly 8 handshakes, then din_ready = 1.
- Input gaps and version change:
  - Stimulus: din_valid random 50 %; version flips after the first key byte.
  - Required response: the frame uses the first sampled version, and byte count and order are unaffected.
- Reset mid-frame: assert reset after 5 key bytes, then run a full frame with a stub core (ct = pt ^ key[0:63]) → no stale bytes; output equals the new frame's expected value.
- Two back-to-back frames: version 0 then version 1 → second frame's core_key has no leftover bits from the first, and both outputs are correct.
